// File: rtl/uop_pkg.sv
// ----------------------------------------------------------------------------
// uop_pkg
//   Shared types for the decoded-uop queue sitting between the decoder and the
//   backend RAT.
//   - uop_insn     : one decoded uop as carried through the queue
//   - QUEUE_WIDTH  : enqueue/dequeue width (fixed at 2)
//   - uop_push_count() : number of uops a push valid vector represents
// ----------------------------------------------------------------------------
package uop_pkg;

    localparam int QUEUE_WIDTH = 2;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [9:0]  pc_lo;
    } uop_insn;

    // Slot1 may only be valid together with slot0; the lone-slot1 pattern
    // is treated as no push at all.
    function automatic logic [1:0] uop_push_count(input logic [1:0] valid);
        logic [1:0] n;
        case (valid)
            2'b01:   n = 2'd1;
            2'b11:   n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uop_queue_storage.sv
// ----------------------------------------------------------------------------
// uop_queue_storage
//   DEPTH-entry array of uop_insn with two write ports and two asynchronous
//   read ports. The array contents are never reset.
// Ports
//   clk_in                  clock
//   we0_in/waddr0_in/wdata0_in   write port 0 (older uop of a push)
//   we1_in/waddr1_in/wdata1_in   write port 1 (younger uop of a push)
//   raddr0_in/rdata0_out    async read port 0
//   raddr1_in/rdata1_out    async read port 1
// ----------------------------------------------------------------------------
module uop_queue_storage
    import uop_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             we0_in,
    input  logic [PTR_W-1:0] waddr0_in,
    input  uop_insn          wdata0_in,
    input  logic             we1_in,
    input  logic [PTR_W-1:0] waddr1_in,
    input  uop_insn          wdata1_in,
    input  logic [PTR_W-1:0] raddr0_in,
    input  logic [PTR_W-1:0] raddr1_in,
    output uop_insn          rdata0_out,
    output uop_insn          rdata1_out
);

    uop_insn mem_q [DEPTH];
    uop_insn mem_d [DEPTH];

    // The two write addresses are always tail and tail+1, so they never
    // collide; port order below is therefore irrelevant.
    always_comb begin
        mem_d = mem_q;
        if (we0_in) mem_d[waddr0_in] = wdata0_in;
        if (we1_in) mem_d[waddr1_in] = wdata1_in;
    end

    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

    assign rdata0_out = mem_q[raddr0_in];
    assign rdata1_out = mem_q[raddr1_in];

endmodule

// File: rtl/uop_queue.sv
// ----------------------------------------------------------------------------
// uop_queue
//   2-wide in-order FIFO of decoded uops between decoder and RAT. Absorbs
//   rename stalls and is emptied by a backend flush.
// Ports
//   clk_in                clock
//   rst_in                synchronous active-high reset (highest priority)
//   flush_in              discard all entries at the next edge
//   enq_valid_in[1:0]     per-slot push valid (slot1 only with slot0)
//   enq_insn_in[1:0]      uops to push, slot0 older
//   enq_ready_out         at least two free entries
//   q_valid_out           at least one entry held
//   instr_valid_out[1:0]  {count>=2, count>=1}
//   instr_out[1:0]        [0]=mem[head], [1]=mem[head+1]
//   q_increment_ready_in  RAT consumes every valid presented slot
//   occupancy_out         current entry count
// ----------------------------------------------------------------------------
module uop_queue
    import uop_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         flush_in,
    input  logic [QUEUE_WIDTH-1:0]       enq_valid_in,
    input  uop_insn [QUEUE_WIDTH-1:0]    enq_insn_in,
    output logic                         enq_ready_out,
    output logic                         q_valid_out,
    output logic [QUEUE_WIDTH-1:0]       instr_valid_out,
    output uop_insn [QUEUE_WIDTH-1:0]    instr_out,
    input  logic                         q_increment_ready_in,
    output logic [CNT_W-1:0]             occupancy_out
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]       enq_n;
    logic [1:0]       deq_n;
    logic             we0, we1;

    // Status is derived from registered count only; a same-cycle pop never
    // raises enq_ready, which keeps ready free of combinational paths.
    assign enq_ready_out      = (count_q <= CNT_W'(DEPTH - 2));
    assign q_valid_out        = (count_q != '0);
    assign instr_valid_out[0] = (count_q != '0);
    assign instr_valid_out[1] = (count_q >= CNT_W'(2));
    assign occupancy_out      = count_q;

    always_comb begin
        enq_n   = enq_ready_out ? uop_push_count(enq_valid_in) : 2'd0;
        deq_n   = '0;
        if (q_valid_out && q_increment_ready_in) begin
            deq_n = instr_valid_out[1] ? 2'd2 : 2'd1;
        end

        we0     = 1'b0;
        we1     = 1'b0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            we0     = (enq_n != 2'd0);
            we1     = (enq_n == 2'd2);
            head_d  = head_q + PTR_W'(deq_n);
            tail_d  = tail_q + PTR_W'(enq_n);
            count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Pointer+1 wraps naturally at PTR_W bits, so a pair may straddle
    // entry DEPTH-1 -> 0 on both the write and read side.
    uop_queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk_in     (clk_in),
        .we0_in     (we0),
        .waddr0_in  (tail_q),
        .wdata0_in  (enq_insn_in[0]),
        .we1_in     (we1),
        .waddr1_in  (tail_q + PTR_W'(1)),
        .wdata1_in  (enq_insn_in[1]),
        .raddr0_in  (head_q),
        .raddr1_in  (head_q + PTR_W'(1)),
        .rdata0_out (instr_out[0]),
        .rdata1_out (instr_out[1])
    );

    a_no_lone_slot1: assert property (@(posedge clk_in) disable iff (rst_in)
        enq_valid_in != 2'b10);

    a_count_bounded: assert property (@(posedge clk_in) disable iff (rst_in)
        count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_uop_queue.sv
module tb_uop_queue;
    import uop_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b0;
    logic                 flush_in = 1'b0;
    logic [1:0]           enq_valid_in = 2'b00;
    uop_insn [1:0]        enq_insn_in;
    logic                 enq_ready_out;
    logic                 q_valid_out;
    logic [1:0]           instr_valid_out;
    uop_insn [1:0]        instr_out;
    logic                 q_increment_ready_in = 1'b0;
    logic [CW-1:0]        occupancy_out;

    always #5 clk_in = ~clk_in;

    uop_queue #(.DEPTH(DEPTH)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .flush_in             (flush_in),
        .enq_valid_in         (enq_valid_in),
        .enq_insn_in          (enq_insn_in),
        .enq_ready_out        (enq_ready_out),
        .q_valid_out          (q_valid_out),
        .instr_valid_out      (instr_valid_out),
        .instr_out            (instr_out),
        .q_increment_ready_in (q_increment_ready_in),
        .occupancy_out        (occupancy_out)
    );

    // Reference: a plain queue of the uops the RAT has yet to see.
    uop_insn model_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;
    int      seq      = 0;

    typedef struct {
        logic       rst;
        logic       flush;
        logic [1:0] ev;
        logic       incr;
        int         occ;
        logic       qv;
        logic [1:0] iv;
        logic       rdy;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic uop_insn mk_insn();
        uop_insn u;
        u = {$urandom(), 32'(seq)};
        seq++;
        return u;
    endfunction

    task automatic check_outputs(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".occ"}, 64'(occupancy_out), 64'(sz));
        chk({tag, ".qv"}, 64'(q_valid_out), 64'(sz >= 1));
        chk({tag, ".iv"}, 64'(instr_valid_out), 64'({sz >= 2, sz >= 1}));
        chk({tag, ".rdy"}, 64'(enq_ready_out), 64'((DEPTH - sz) >= 2));
        if (sz >= 1) chk({tag, ".slot0"}, 64'(instr_out[0]), 64'(model_q[0]));
        if (sz >= 2) chk({tag, ".slot1"}, 64'(instr_out[1]), 64'(model_q[1]));
    endtask

    // Apply one cycle of inputs, advance the model, then check all outputs.
    task automatic cycle(input logic rst, input logic flush, input logic [1:0] ev,
                         input logic incr, input string tag);
        uop_insn a, b;
        int      sz, npop;
        logic    rdy;
        a = mk_insn();
        b = mk_insn();
        rst_in               = rst;
        flush_in             = flush;
        enq_valid_in         = ev;
        enq_insn_in[0]       = a;
        enq_insn_in[1]       = b;
        q_increment_ready_in = incr;
        sz  = model_q.size();
        rdy = (DEPTH - sz) >= 2;
        @(posedge clk_in);
        if (rst || flush) begin
            model_q.delete();
        end else begin
            npop = incr ? ((sz >= 2) ? 2 : sz) : 0;
            repeat (npop) void'(model_q.pop_front());
            if (rdy && (ev == 2'b01 || ev == 2'b11)) model_q.push_back(a);
            if (rdy && ev == 2'b11) model_q.push_back(b);
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        // rst flush ev incr | occ qv iv rdy
        vt[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b0, 2'b00, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 2'b11, 1'b0, 2, 1'b1, 2'b11, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 2'b01, 1'b0, 3, 1'b1, 2'b11, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1, 1'b1, 2'b01, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 2'b00, 1'b1, 0, 1'b0, 2'b00, 1'b1};
        vt[5]  = '{1'b0, 1'b0, 2'b00, 1'b1, 0, 1'b0, 2'b00, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1, 1'b1, 2'b01, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 2'b11, 1'b1, 2, 1'b1, 2'b11, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 2'b11, 1'b1, 0, 1'b0, 2'b00, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 2'b11, 1'b0, 2, 1'b1, 2'b11, 1'b1};
        vt[10] = '{1'b1, 1'b1, 2'b11, 1'b0, 0, 1'b0, 2'b00, 1'b1};

        enq_insn_in = '0;
        repeat (2) @(posedge clk_in);
        #1;

        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].rst, vt[i].flush, vt[i].ev, vt[i].incr, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.t_occ", i), 64'(occupancy_out), 64'(vt[i].occ));
            chk($sformatf("vec%0d.t_qv", i), 64'(q_valid_out), 64'(vt[i].qv));
            chk($sformatf("vec%0d.t_iv", i), 64'(instr_valid_out), 64'(vt[i].iv));
            chk($sformatf("vec%0d.t_rdy", i), 64'(enq_ready_out), 64'(vt[i].rdy));
        end

        // Fill with pairs from empty: reaches 16, further pushes rejected.
        cycle(1'b1, 1'b0, 2'b00, 1'b0, "full.rst");
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 2'b11, 1'b0, "full.fill");
        chk("full.occ16", 64'(occupancy_out), 64'(16));
        chk("full.rdy0", 64'(enq_ready_out), 64'(0));
        cycle(1'b0, 1'b0, 2'b11, 1'b0, "full.extra");
        chk("full.still16", 64'(occupancy_out), 64'(16));
        cycle(1'b0, 1'b0, 2'b11, 1'b1, "full.popnopush");
        chk("full.occ14", 64'(occupancy_out), 64'(14));
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 2'b00, 1'b1, "full.drain");

        // Odd start: stops at 15 with ready low.
        cycle(1'b0, 1'b0, 2'b01, 1'b0, "odd.one");
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 2'b11, 1'b0, "odd.fill");
        chk("odd.occ15", 64'(occupancy_out), 64'(15));
        chk("odd.rdy0", 64'(enq_ready_out), 64'(0));
        cycle(1'b0, 1'b0, 2'b11, 1'b1, "odd.popnopush");
        chk("odd.occ13", 64'(occupancy_out), 64'(13));
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 2'b00, 1'b1, "odd.drain");
        chk("odd.empty", 64'(q_valid_out), 64'(0));

        // Steady push 2 + pop 2 across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 2'b11, 1'b1, "steady");
            chk("steady.occ2", 64'(occupancy_out), 64'(2));
        end
        cycle(1'b0, 1'b0, 2'b00, 1'b1, "steady.drain");

        // Flush at occupancy 10 with push+pop in the same cycle.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'b11, 1'b0, "fl.fill");
        chk("fl.occ10", 64'(occupancy_out), 64'(10));
        cycle(1'b0, 1'b1, 2'b11, 1'b1, "fl.flush");
        chk("fl.occ0", 64'(occupancy_out), 64'(0));
        chk("fl.qv0", 64'(q_valid_out), 64'(0));
        chk("fl.rdy1", 64'(enq_ready_out), 64'(1));
        cycle(1'b0, 1'b0, 2'b01, 1'b0, "fl.after");
        cycle(1'b0, 1'b0, 2'b00, 1'b1, "fl.pop");

        // Reset at occupancy 6 with push and flush asserted.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b11, 1'b0, "rs.fill");
        chk("rs.occ6", 64'(occupancy_out), 64'(6));
        cycle(1'b1, 1'b1, 2'b11, 1'b1, "rs.reset");
        chk("rs.occ0", 64'(occupancy_out), 64'(0));
        chk("rs.iv0", 64'(instr_valid_out), 64'(0));

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            int         r, k;
            logic [1:0] ev;
            r  = $urandom_range(0, 99);
            k  = $urandom_range(0, 2);
            ev = (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b11);
            cycle(r < 1, (r >= 1) && (r < 3), ev, $urandom_range(0, 9) < 4, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
